// File: rtl/operand_select_pipe.sv
// operand_select_pipe: registered 4-way operand select (const/a/b/zero)
// feeding a 2-entry valid/ready skid buffer for the multiplier port.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   flush           sync clear of buffered entries
//   in_valid/ready  upstream handshake (in_ready registered)
//   sel, a, b       source select and operands
//   out_valid/ready downstream handshake
//   out_data        selected value, out_src its captured sel
module operand_select_pipe #(
  parameter int unsigned      WIDTH      = 10,
  parameter logic [WIDTH-1:0] CONST_SEL0 = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] skid_data;
  logic [1:0]       skid_src;
  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic             load_skid;
  logic             pop_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    sel_data = '0;
    unique case (1'b1)
      (sel == 2'b00): sel_data = CONST_SEL0;
      (sel == 2'b01): sel_data = a;
      (sel == 2'b10): sel_data = b;
      default:        sel_data = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (in_fire) state_nxt = ONE;
      end
      ONE: begin
        if (in_fire && !out_fire)
          state_nxt = FULL;
        else if (!in_fire && out_fire)
          state_nxt = EMPTY;
      end
      FULL: begin
        if (out_fire) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Main takes the new entry when it is free or being
  // drained this cycle; otherwise the new entry parks in skid.
  assign load_main = in_fire &
                     ((state == EMPTY) | out_fire);
  assign load_skid = in_fire & (state == ONE) & ~out_fire;
  assign pop_skid  = (state == FULL) & out_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_src   <= '0;
      skid_data <= '0;
      skid_src  <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      if (load_main) begin
        out_data <= sel_data;
        out_src  <= sel;
      end else if (pop_skid) begin
        out_data <= skid_data;
        out_src  <= skid_src;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_src  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_operand_select_pipe.sv
// tb_operand_select_pipe: directed table, corner sequences
// and a scoreboarded random run for operand_select_pipe.
module tb_operand_select_pipe;

  localparam int W = 10;
  localparam logic [W-1:0] A0 = 10'h155;
  localparam logic [W-1:0] B0 = 10'h2AA;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;

  operand_select_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic         fl;
    logic         ordy;
    logic [1:0]   sel;
    logic         ev;
    logic         er;
    logic [W-1:0] ed;
    logic [1:0]   es;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   s;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic fl,
                     input logic ordy, input logic [1:0] s,
                     input logic ev, input logic er,
                     input logic [W-1:0] ed,
                     input logic [1:0] es);
    vec_t v;
    v.iv = iv; v.fl = fl; v.ordy = ordy; v.sel = s;
    v.ev = ev; v.er = er; v.ed = ed; v.es = es;
    vecs.push_back(v);
  endtask

  function automatic logic [W-1:0] ref_sel(
      input logic [1:0] s, input logic [W-1:0] aa,
      input logic [W-1:0] bb);
    case (s)
      2'b00:   return {W{1'b1}};
      2'b01:   return aa;
      2'b10:   return bb;
      default: return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    sel = 2'b00; a = A0; b = B0; out_ready = 1'b1;

    // async reset mid-cycle, checked before any clock edge
    #3 rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_data", out_data, 0);
    check("rst_src", out_src, 0);
    step();
    rst = 1'b0;

    // select coverage, back to back
    add(1, 0, 1, 2'b00, 1, 1, 10'h3FF, 2'd0);
    add(1, 0, 1, 2'b01, 1, 1, 10'h155, 2'd1);
    add(1, 0, 1, 2'b10, 1, 1, 10'h2AA, 2'd2);
    add(1, 0, 1, 2'b11, 1, 1, 10'h000, 2'd3);
    add(0, 0, 1, 2'b00, 0, 1, 10'h000, 2'd0);
    // backpressure into skid, 5 stall cycles
    add(1, 0, 0, 2'b01, 1, 1, 10'h155, 2'd1);
    add(1, 0, 0, 2'b10, 1, 0, 10'h155, 2'd1);
    for (int k = 0; k < 5; k++)
      add(1, 0, 0, 2'b00, 1, 0, 10'h155, 2'd1);
    add(0, 0, 1, 2'b00, 1, 1, 10'h2AA, 2'd2);
    add(0, 0, 1, 2'b00, 0, 1, 10'h000, 2'd0);
    // flush while FULL with in_valid sel=00
    add(1, 0, 0, 2'b01, 1, 1, 10'h155, 2'd1);
    add(1, 0, 0, 2'b10, 1, 0, 10'h155, 2'd1);
    add(1, 1, 0, 2'b00, 0, 1, 10'h000, 2'd0);
    add(0, 0, 1, 2'b00, 0, 1, 10'h000, 2'd0);
    add(0, 0, 1, 2'b00, 0, 1, 10'h000, 2'd0);
    // flush in ONE discards a coincident in_fire
    add(1, 0, 1, 2'b01, 1, 1, 10'h155, 2'd1);
    add(1, 1, 1, 2'b00, 0, 1, 10'h000, 2'd0);
    add(0, 0, 1, 2'b00, 0, 1, 10'h000, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid  = vecs[i].iv;
      flush     = vecs[i].fl;
      out_ready = vecs[i].ordy;
      sel       = vecs[i].sel;
      step();
      check($sformatf("vec%0d_valid", i),
            out_valid, vecs[i].ev);
      check($sformatf("vec%0d_ready", i),
            in_ready, vecs[i].er);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_data", i),
              out_data, vecs[i].ed);
        check($sformatf("vec%0d_src", i),
              out_src, vecs[i].es);
      end
    end
    flush = 1'b0;

    // async reset while FULL
    in_valid = 1'b1; out_ready = 1'b0; sel = 2'b01;
    step();
    sel = 2'b10;
    step();
    check("stall_full_ready", in_ready, 0);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_data", out_data, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b1; sel = 2'b11; out_ready = 1'b1;
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 0);
    check("post_rst_src", out_src, 3);
    in_valid = 1'b0;
    step();
    check("post_rst_no_stale", out_valid, 0);

    // random run against a queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic fi;
      logic fo;
      ent_t e;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      sel       = 2'($urandom_range(0, 3));
      a         = W'($urandom);
      b         = W'($urandom);
      @(negedge clk);
      check("rnd_ready", in_ready, (q.size() < 2));
      check("rnd_valid", out_valid, (q.size() > 0));
      if (q.size() > 0) begin
        check("rnd_data", out_data, q[0].d);
        check("rnd_src", out_src, q[0].s);
      end
      fi = in_valid && (q.size() < 2);
      fo = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (fo) void'(q.pop_front());
        if (fi) begin
          e.d = ref_sel(sel, a, b);
          e.s = sel;
          q.push_back(e);
        end
      end
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_select_pipe.md
Name: operand_select_pipe

Overview:
- Parametrised, registered successor to the 2-bit-select operand mux used in the RSA datapath.
- Selects one of four sources per transaction:
  - constant CONST_SEL0
  - operand a
  - operand b
  - zero
- Presents the result through a 2-entry valid/ready skid buffer, so the modular-multiplier front end can stall without losing operands.
- Sits between the exponentiation controller (drives sel/a/b) and the Montgomery multiplier operand port.

Parameters:
- WIDTH, 10, bit width of a, b and out_data.
- CONST_SEL0, {WIDTH{1'b1}} (all ones), value driven for sel=2'b00.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous clear of buffered contents.
- in_valid  input  1  upstream transaction valid.
- in_ready  output  1  upstream may transfer; registered.
- sel  input  2  source select: 00=CONST_SEL0, 01=a, 10=b, 11=zero.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  out_data/out_src valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  selected value.
- out_src  output  2  copy of sel captured with the transaction.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_data=0, out_src=0, skid registers=0.
- Transfer rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Selection is combinational on the input side and captured at in_fire. Value and sel are stored together.
- Latency: in_fire at edge N makes out_valid=1 after edge N (visible in cycle N+1). No combinational path from in_* to out_*.
- States:
  - EMPTY: in_ready=1, out_valid=0.
    - in_fire -> load main, go ONE.
  - ONE: in_ready=1, out_valid=1.
    - in_fire & out_fire -> load main with new entry, stay ONE.
    - in_fire & !out_fire -> load skid, go FULL.
    - !in_fire & out_fire -> go EMPTY.
    - Neither -> hold.
  - FULL: in_ready=0, out_valid=1.
    - out_fire -> main<=skid, go ONE.
    - Otherwise hold.
- in_ready is registered and equals (next_state != FULL). It never depends combinationally on out_ready.
- Stability: while out_valid=1 & out_ready=0, out_data and out_src must not change.
- Ordering: strict FIFO; the skid entry is always emitted after the main entry.
- in_valid while in_ready=0: ignored, no capture. Upstream holds its data.
- flush (synchronous, priority over everything except rst):
  - Next edge: state=EMPTY, out_valid=0, in_ready=1.
  - An in_fire coincident with flush is discarded.
  - out_data/out_src retain their old values (don't-care while invalid).
- rst mid-transaction: all contents lost immediately; outputs take reset values asynchronously.
- sel=11 yields all-zero data with out_src=11.
- CONST_SEL0 is truncated/extended to WIDTH per Verilog assignment rules. The default is all ones for any WIDTH.
- Throughput: one transaction per cycle sustained when out_ready=1.

Test Plan:
- Reset, idle:
  - Stimulus: rst pulse mid-cycle, then released.
  - Response: out_valid=0, in_ready=1, out_data=0 immediately at assertion.
- Select coverage (WIDTH=10, a=10'h155, b=10'h2AA, out_ready=1):
  - Stimulus: sel 00, 01, 10, 11 on consecutive cycles.
  - Response: out_data 3FF, 155, 2AA, 000 one cycle later; out_src 0, 1, 2, 3; no gaps.
- Backpressure/skid:
  - Stimulus: out_ready=0; send sel=01 then sel=10.
  - Response: in_ready=0 after the second capture; out_data stays 155 for 5 stall cycles.
  - Then out_ready=1: emits 155 then 2AA; in_ready returns to 1.
- Flush:
  - Stimulus: in FULL state, flush=1 together with in_valid=1 (sel=00).
  - Response: next cycle out_valid=0, in_ready=1; no 3FF ever emitted.
- Async reset mid-stall:
  - Stimulus: in FULL state, assert rst between edges.
  - Response: out_valid=0 at once.
  - After release, a new sel=11 emerges alone as 000 with no stale entries.
- Random stress (constrained random):
  - Stimulus: 10k cycles with random in_valid/out_ready/sel/a/b.
  - Response: a scoreboard checks FIFO order, data and src. The following assertions must hold:
    - Outputs stable while stalled.
    - in_ready=0 only when two entries are held.
